// File: rtl/alu_result_checker_if.sv
// Sample/verdict bundle between an ALU stimulus driver and alu_result_checker.
// Handshake: valid-only stream, no backpressure. A sample (alu_code, a, b,
// result, flag_c) is consumed on any rising edge where in_valid is high, the
// checker is in RUN, start is low and fewer than NUM_VECTORS samples have been
// accepted since the last start; otherwise it is dropped silently.
interface alu_result_checker_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             in_valid;
  logic [2:0]       alu_code;
  logic [3:0]       a;
  logic [3:0]       b;
  logic [7:0]       result;
  logic             flag_c;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] chk_count;
  logic [CNT_W-1:0] err_count;
  logic             fe_valid;
  logic [2:0]       fe_code;
  logic [3:0]       fe_a;
  logic [3:0]       fe_b;
  logic [7:0]       fe_result;
  logic [8:0]       fe_expect;

  modport master (
    output start, in_valid, alu_code, a, b, result, flag_c,
    input  busy, done, pass, chk_count, err_count,
           fe_valid, fe_code, fe_a, fe_b, fe_result, fe_expect
  );

  modport slave (
    input  start, in_valid, alu_code, a, b, result, flag_c,
    output busy, done, pass, chk_count, err_count,
           fe_valid, fe_code, fe_a, fe_b, fe_result, fe_expect
  );
endinterface

// File: rtl/alu_result_checker.sv
// Response monitor for alu_4bit: recomputes the golden result for every
// applied sample, counts checks and mismatches, captures the first failure and
// delivers a pass/fail verdict after NUM_VECTORS compares.
// Two-stage pipeline: stage 1 registers the sample with its golden value,
// stage 2 compares and updates the counters / first-error capture.
module alu_result_checker #(
  parameter int NUM_VECTORS = 8,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_result_checker_if.slave  bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_NUM  = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] LP_SAT  = '1;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CNT_W-1:0] r_acc_cnt;
  logic [CNT_W-1:0] r_chk_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] w_err_nxt;

  logic             r_s1_valid;
  logic [2:0]       r_s1_code;
  logic [3:0]       r_s1_a;
  logic [3:0]       r_s1_b;
  logic [7:0]       r_s1_result;
  logic             r_s1_flag;
  logic [8:0]       r_s1_exp;

  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_fe_valid;
  logic [2:0]       r_fe_code;
  logic [3:0]       r_fe_a;
  logic [3:0]       r_fe_b;
  logic [7:0]       r_fe_result;
  logic [8:0]       r_fe_expect;

  logic [4:0]       w_sum;
  logic [4:0]       w_diff;
  logic [7:0]       w_prod;
  logic [8:0]       w_gold;
  logic             w_accept;
  logic             w_compare;
  logic             w_mismatch;
  logic             w_last_cmp;

  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};
  assign w_prod = {4'b0, bus.a} * {4'b0, bus.b};

  // Golden {carry, result} for the sample currently on the bus.
  always_comb begin
    w_gold = '0;
    unique case (bus.alu_code)
      3'b000:  w_gold = {w_sum[4], 3'b0, w_sum};
      3'b001:  w_gold = {w_diff[4], 4'b0, w_diff[3:0]};
      3'b010:  w_gold = {1'b0, w_prod};
      3'b011:  w_gold = {5'b0, bus.a & bus.b};
      3'b100:  w_gold = {5'b0, bus.a | bus.b};
      3'b101:  w_gold = {5'b0, bus.a ^ bus.b};
      3'b110:  w_gold = {5'b0, ~bus.a};
      3'b111:  w_gold = {5'b0, ~(bus.a & bus.b)};
      default: w_gold = '0;
    endcase
  end

  // A start cycle drops both the incoming sample and the one in stage 1.
  assign w_accept   = (r_state == S_RUN) && bus.in_valid && !bus.start &&
                      (r_acc_cnt != LP_NUM);
  assign w_compare  = r_s1_valid && !bus.start;
  assign w_mismatch = (r_s1_result != r_s1_exp[7:0]) || (r_s1_flag != r_s1_exp[8]);
  assign w_last_cmp = w_compare && (r_chk_cnt == LP_LAST);

  // Error count after this edge, shared by the counter and the pass flag.
  always_comb begin
    w_err_nxt = r_err_cnt;
    if (bus.start) begin
      w_err_nxt = '0;
    end else if (w_compare && w_mismatch && (r_err_cnt != LP_SAT)) begin
      w_err_nxt = r_err_cnt + 1'b1;
    end
  end

  // Next-state logic: start always (re)enters RUN, last compare ends it.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (bus.start) w_state_nxt = S_RUN;
               else if (w_last_cmp) w_state_nxt = S_DONE;
      S_DONE:  if (bus.start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN);
      r_done <= (w_state_nxt == S_DONE);
      r_pass <= (w_state_nxt == S_DONE) && (w_err_nxt == '0);
    end
  end

  // Stage 1: capture accepted sample together with its golden value.
  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      r_s1_valid  <= 1'b0;
      r_s1_code   <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_result <= '0;
      r_s1_flag   <= 1'b0;
      r_s1_exp    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_code   <= bus.alu_code;
        r_s1_a      <= bus.a;
        r_s1_b      <= bus.b;
        r_s1_result <= bus.result;
        r_s1_flag   <= bus.flag_c;
        r_s1_exp    <= w_gold;
      end
    end
  end

  // Accept, check and error counters.
  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      r_acc_cnt <= '0;
      r_chk_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_accept)  r_acc_cnt <= r_acc_cnt + 1'b1;
      if (w_compare) r_chk_cnt <= r_chk_cnt + 1'b1;
      r_err_cnt <= w_err_nxt;
    end
  end

  // Stage 2 first-error capture: loads once, then frozen until start/rst.
  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      r_fe_valid  <= 1'b0;
      r_fe_code   <= '0;
      r_fe_a      <= '0;
      r_fe_b      <= '0;
      r_fe_result <= '0;
      r_fe_expect <= '0;
    end else if (w_compare && w_mismatch && !r_fe_valid) begin
      r_fe_valid  <= 1'b1;
      r_fe_code   <= r_s1_code;
      r_fe_a      <= r_s1_a;
      r_fe_b      <= r_s1_b;
      r_fe_result <= r_s1_result;
      r_fe_expect <= r_s1_exp;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.chk_count = r_chk_cnt;
  assign bus.err_count = r_err_cnt;
  assign bus.fe_valid  = r_fe_valid;
  assign bus.fe_code   = r_fe_code;
  assign bus.fe_a      = r_fe_a;
  assign bus.fe_b      = r_fe_b;
  assign bus.fe_result = r_fe_result;
  assign bus.fe_expect = r_fe_expect;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: directed scenarios plus randomized runs,
// scored against an arithmetic model of the 4-bit ALU.
module tb_alu_result_checker;

  localparam int NV = 8;
  localparam int CW = 16;
  localparam int EW = 29;  // {flag, code, a, b, result, exp9}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_result_checker_if #(.CNT_W(CW)) bus ();
  logic [1:0] dbg_state;

  alu_result_checker #(.NUM_VECTORS(NV), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  bit            model_run;
  int            n_checks;
  int            n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU in plain integer arithmetic, returns {carry, result}.
  function automatic logic [8:0] gold(input int code, input int a, input int b);
    int r;
    int c;
    logic [31:0] rr;
    c = 0;
    case (code)
      0: begin r = a + b; c = (r > 15) ? 1 : 0; end
      1: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
      2: r = a * b;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = 15 - a;
      default: r = 15 - (a & b);
    endcase
    rr = r;
    return {c[0], rr[7:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    model_run = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_start();
    bus.in_valid = 1'b0;
    bus.start = 1'b1;
    exp_q.delete();
    model_run = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Presents one sample for one cycle; leaves in_valid high for back-to-back use.
  task automatic send(input int code, input int a, input int b, input int res, input int flag);
    logic [2:0] c3;
    logic [3:0] a4;
    logic [3:0] b4;
    logic [7:0] r8;
    logic       f1;
    c3 = code[2:0]; a4 = a[3:0]; b4 = b[3:0]; r8 = res[7:0]; f1 = flag[0];
    bus.in_valid = 1'b1;
    bus.alu_code = c3;
    bus.a = a4;
    bus.b = b4;
    bus.result = r8;
    bus.flag_c = f1;
    if (model_run && exp_q.size() < NV)
      exp_q.push_back({f1, c3, a4, b4, r8, gold(code, a, b)});
    step();
  endtask

  task automatic send_ok(input int code, input int a, input int b);
    logic [8:0] g;
    g = gold(code, a, b);
    send(code, a, b, int'(g[7:0]), int'(g[8]));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (bus.done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (bus.done !== 1'b1) check_eq({tag, "_done_timeout"}, 32'(bus.done), 32'd1);
  endtask

  // Compares the verdict outputs against what the queued samples imply.
  task automatic check_verdict(input string tag);
    int err;
    bit found;
    logic [EW-1:0] f;
    err = 0;
    found = 1'b0;
    f = '0;
    foreach (exp_q[i]) begin
      if ((exp_q[i][16:9] != exp_q[i][7:0]) || (exp_q[i][28] != exp_q[i][8])) begin
        err++;
        if (!found) begin
          found = 1'b1;
          f = exp_q[i];
        end
      end
    end
    check_eq({tag, "_done"}, 32'(bus.done), 32'd1);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_chk"}, 32'(bus.chk_count), 32'(exp_q.size()));
    check_eq({tag, "_err"}, 32'(bus.err_count), 32'(err));
    check_eq({tag, "_pass"}, 32'(bus.pass), (err == 0) ? 32'd1 : 32'd0);
    check_eq({tag, "_fe_valid"}, 32'(bus.fe_valid), 32'(found));
    if (found) begin
      check_eq({tag, "_fe_code"}, 32'(bus.fe_code), 32'(f[27:25]));
      check_eq({tag, "_fe_a"}, 32'(bus.fe_a), 32'(f[24:21]));
      check_eq({tag, "_fe_b"}, 32'(bus.fe_b), 32'(f[20:17]));
      check_eq({tag, "_fe_result"}, 32'(bus.fe_result), 32'(f[16:9]));
      check_eq({tag, "_fe_expect"}, 32'(bus.fe_expect), 32'(f[8:0]));
    end
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_pass"}, 32'(bus.pass), 32'd0);
    check_eq({tag, "_chk"}, 32'(bus.chk_count), 32'd0);
    check_eq({tag, "_err"}, 32'(bus.err_count), 32'd0);
    check_eq({tag, "_fe_valid"}, 32'(bus.fe_valid), 32'd0);
    check_eq({tag, "_fe_expect"}, 32'(bus.fe_expect), 32'd0);
    check_eq({tag, "_fe_code"}, 32'(bus.fe_code), 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // Eight A/5 samples over all opcodes, optionally corrupting selected codes.
  task automatic run_all_codes(input int bad_mask, input int bad_xor);
    logic [8:0] g;
    for (int c = 0; c < 8; c++) begin
      g = gold(c, 10, 5);
      if (bad_mask[c]) send(c, 10, 5, int'(g[7:0]) ^ bad_xor, int'(g[8]));
      else             send(c, 10, 5, int'(g[7:0]), int'(g[8]));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    model_run = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_code = '0;
    bus.a = '0;
    bus.b = '0;
    bus.result = '0;
    bus.flag_c = 1'b0;

    // T1: reset state, clean pass, done two cycles after last sample
    do_reset();
    check_cleared("rst");
    do_start();
    check_eq("t1_busy", 32'(bus.busy), 32'd1);
    check_eq("t1_state", 32'(dbg_state), 32'd1);
    run_all_codes(0, 0);
    bus.in_valid = 1'b0;
    check_eq("t1_done_early", 32'(bus.done), 32'd0);
    step();
    check_eq("t1_done_lat", 32'(bus.done), 32'd1);
    check_eq("t1_state_done", 32'(dbg_state), 32'd2);
    check_verdict("t1");

    // T2: MUL result wrong (0x31 instead of 0x32)
    do_start();
    run_all_codes(8'b0000_0100, 8'h03);
    wait_done("t2", 10);
    check_verdict("t2");
    check_eq("t2_fe_expect_abs", 32'(bus.fe_expect), 32'h032);
    check_eq("t2_fe_result_abs", 32'(bus.fe_result), 32'h31);

    // T3: carry/borrow boundaries, then a wrong flag
    do_start();
    send(0, 15, 1, 8'h10, 1);
    send(1, 3, 5, 8'h0E, 1);
    send(0, 3, 4, 8'h07, 1);
    for (int i = 0; i < 5; i++) send_ok(i, i + 2, 15 - i);
    wait_done("t3", 10);
    check_verdict("t3");
    check_eq("t3_err_abs", 32'(bus.err_count), 32'd1);
    check_eq("t3_fe_expect_abs", 32'(bus.fe_expect), 32'h007);

    // T4: two mismatches, first-error capture holds code 3 only
    do_start();
    run_all_codes(8'b0010_1000, 8'h01);
    wait_done("t4", 10);
    check_verdict("t4");
    check_eq("t4_fe_code_abs", 32'(bus.fe_code), 32'd3);
    check_eq("t4_err_abs", 32'(bus.err_count), 32'd2);

    // T5: in_valid while IDLE ignored, extras after the 8th ignored
    do_reset();
    for (int i = 0; i < 3; i++) send_ok(i, 1, 2);
    bus.in_valid = 1'b0;
    check_eq("t5_idle_chk", 32'(bus.chk_count), 32'd0);
    do_start();
    for (int i = 0; i < NV + 3; i++) send_ok(i % 8, i, 3);
    idle(4);
    check_verdict("t5");
    // rst on the 4th sample aborts the run
    do_start();
    for (int i = 0; i < 3; i++) send_ok(i, 7, 9);
    rst = 1'b1;
    send(0, 1, 1, 0, 0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    model_run = 1'b0;
    exp_q.delete();
    check_cleared("t5_rst");
    idle(3);
    check_cleared("t5_rst_hold");

    // T6: restart from DONE clears everything, clean rerun passes
    do_start();
    run_all_codes(8'b0000_0001, 8'h40);
    wait_done("t6a", 10);
    check_verdict("t6a");
    do_start();
    check_eq("t6_busy", 32'(bus.busy), 32'd1);
    check_eq("t6_done", 32'(bus.done), 32'd0);
    check_eq("t6_chk", 32'(bus.chk_count), 32'd0);
    check_eq("t6_err", 32'(bus.err_count), 32'd0);
    check_eq("t6_fe_valid", 32'(bus.fe_valid), 32'd0);
    run_all_codes(0, 0);
    wait_done("t6b", 10);
    check_verdict("t6b");

    // Randomized runs with gaps, corruption and occasional mid-run restart
    for (int r = 0; r < 30; r++) begin
      int code;
      int a;
      int b;
      int res;
      int flag;
      logic [8:0] g;
      do_start();
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 5)); k++)
          send_ok($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        do_start();
      end
      for (int k = 0; k < NV + int'($urandom_range(0, 3)); k++) begin
        code = $urandom_range(0, 7);
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        g = gold(code, a, b);
        res = int'(g[7:0]);
        flag = int'(g[8]);
        if ($urandom_range(0, 5) == 0) res = res ^ (1 << $urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) flag = flag ^ 1;
        send(code, a, b, res, flag);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      wait_done("rnd", 20);
      check_verdict("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
